seq_chunk_compare: RTL and testbench



---
 rtl/seq_chunk_compare_if.sv | 25 ++
 rtl/seq_chunk_compare.sv | 150 +++++++++++++++
 tb/tb_seq_chunk_compare.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/seq_chunk_compare_if.sv
// Compare request/result bundle for seq_chunk_compare.
// master drives start/mode/A/B; slave returns busy/done/OUT/lt/eq.
interface seq_chunk_compare_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] OUT;
  logic             lt;
  logic             eq;

  modport master (
    output start, mode, A, B,
    input  busy, done, OUT, lt, eq
  );

  modport slave (
    input  start, mode, A, B,
    output busy, done, OUT, lt, eq
  );
endinterface

// File: rtl/seq_chunk_compare.sv
// Multi-cycle SLT/SLTU/SEQ/SNE comparator, one CHUNK slice per clock, MSB first.
// Ports: clk, reset (sync, active-high), bus (seq_chunk_compare_if.slave).
// Optional SEQ_COMPARE_EARLY_EXIT_EN: finish on the first differing slice.
module seq_chunk_compare #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic clk,
  input  logic reset,
  seq_chunk_compare_if.slave bus
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IW-1:0] TOP = IW'(NUM_CHUNKS - 1);

  localparam logic [1:0] M_SLT  = 2'b00;
  localparam logic [1:0] M_SLTU = 2'b01;
  localparam logic [1:0] M_SEQ  = 2'b10;
  localparam logic [1:0] M_SNE  = 2'b11;

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
    $error("seq_chunk_compare: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;

  logic [NUM_CHUNKS-1:0][CHUNK-1:0] a_q;
  logic [NUM_CHUNKS-1:0][CHUNK-1:0] b_q;
  logic [1:0]    mode_q;
  logic [IW-1:0] idx;
  logic          decided;
  logic          lt_int;

  logic busy_q;
  logic done_q;
  logic out_q;
  logic lt_q;
  logic eq_q;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic             slice_lt;
  logic             decide_now;
  logic             pred;
  logic             last;

  // Flipping the sign bit of the top slice maps two's-complement
  // order onto plain unsigned order for the whole word.
  always_comb begin
    a_sl = a_q[idx];
    b_sl = b_q[idx];
    if ((mode_q == M_SLT) && (idx == TOP)) begin
      a_sl[CHUNK-1] = ~a_sl[CHUNK-1];
      b_sl[CHUNK-1] = ~b_sl[CHUNK-1];
    end
    slice_lt   = a_sl < b_sl;
    decide_now = !decided && (a_sl != b_sl);
    last       = (idx == '0);
  end

  always_comb begin
    pred = 1'b0;
    unique case (1'b1)
      (mode_q == M_SLT),
      (mode_q == M_SLTU): pred = lt_int;
      (mode_q == M_SEQ):  pred = !decided;
      (mode_q == M_SNE):  pred = decided;
      default:            pred = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= M_SLT;
      idx     <= TOP;
      decided <= 1'b0;
      lt_int  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            mode_q  <= bus.mode;
            idx     <= TOP;
            decided <= 1'b0;
            lt_int  <= 1'b0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (decide_now) begin
            decided <= 1'b1;
            lt_int  <= slice_lt;
          end
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
          if (decide_now || last) begin
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
`else
          if (last) begin
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
`endif
        end
        DONE: begin
          done_q <= 1'b1;
          lt_q   <= lt_int;
          eq_q   <= !decided;
          out_q  <= pred;
          busy_q <= 1'b0;
          idx    <= TOP;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.OUT  = {{(WIDTH-1){1'b0}}, out_q};
  assign bus.lt   = lt_q;
  assign bus.eq   = eq_q;

endmodule

// File: tb/tb_seq_chunk_compare.sv
// Directed self-checking bench for seq_chunk_compare (WIDTH=32, CHUNK=8).
// Latency expectations follow SEQ_COMPARE_EARLY_EXIT_EN when defined.
module tb_seq_chunk_compare;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  seq_chunk_compare_if #(.WIDTH(W)) cmp ();

  seq_chunk_compare #(.WIDTH(W), .CHUNK(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cmp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
    for (int i = 3; i >= 0; i--)
      if (a[i*8 +: 8] != b[i*8 +: 8]) return (4 - i) + 1;
`endif
    return 5;
  endfunction

  // n counts edges from the caller's point; -1 means no done seen.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n++;
      if (cmp.done) return;
    end
    n = -1;
  endtask

  task automatic run(input string tag, input logic [1:0] m,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic o, input logic l, input logic e);
    int n;
    @(negedge clk);
    cmp.start = 1'b1;
    cmp.mode  = m;
    cmp.A     = a;
    cmp.B     = b;
    @(posedge clk); #1;
    cmp.start = 1'b0;
    cmp.mode  = ~m;
    cmp.A     = ~a;
    cmp.B     = ~b;
    chk({tag, "_busy"}, 64'(cmp.busy), 64'd1);
    wait_done(0, n);
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat(a, b)));
    chk({tag, "_out"}, 64'(cmp.OUT), {63'd0, o});
    chk({tag, "_lt"}, 64'(cmp.lt), 64'(l));
    chk({tag, "_eq"}, 64'(cmp.eq), 64'(e));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'(cmp.done), 64'd0);
    chk({tag, "_hold"}, 64'(cmp.OUT), {63'd0, o});
  endtask

  initial begin
    int n;
    int cnt;
    reset     = 1'b1;
    cmp.start = 1'b0;
    cmp.mode  = 2'b00;
    cmp.A     = '0;
    cmp.B     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(cmp.busy), 64'd0);
    chk("rst_done", 64'(cmp.done), 64'd0);
    chk("rst_out", 64'(cmp.OUT), 64'd0);
    chk("rst_lt", 64'(cmp.lt), 64'd0);
    chk("rst_eq", 64'(cmp.eq), 64'd0);
    reset = 1'b0;

    run("slt_min_0", 2'b00, 32'h8000_0000, 32'h0, 1'b1, 1'b1, 1'b0);
    run("sltu_min_0", 2'b01, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    run("slt_1_min", 2'b00, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run("sltu_1_min", 2'b01, 32'h1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    run("slt_50_60", 2'b00, 32'd50, 32'd60, 1'b1, 1'b1, 1'b0);
    run("slt_m1_1", 2'b00, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 1'b0);
    run("sltu_m1_1", 2'b01, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    run("seq_eq", 2'b10, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    run("sne_eq", 2'b11, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    run("seq_ne", 2'b10, 32'h1234_5678, 32'h1234_5679, 1'b0, 1'b1, 1'b0);
    run("sne_ne", 2'b11, 32'h1234_5678, 32'h1234_5679, 1'b1, 1'b1, 1'b0);

    // start pulsed while busy must be ignored
    @(negedge clk);
    cmp.start = 1'b1; cmp.mode = 2'b01; cmp.A = 32'd1; cmp.B = 32'd2;
    @(posedge clk); #1;
    cmp.start = 1'b0;
    @(posedge clk); #1;
    cmp.start = 1'b1; cmp.mode = 2'b10; cmp.A = 32'd5; cmp.B = 32'd1;
    @(posedge clk); #1;
    cmp.start = 1'b0;
    wait_done(2, n);
    chk("ign_lat", 64'(n), 64'd5);
    chk("ign_out", 64'(cmp.OUT), 64'd1);
    chk("ign_lt", 64'(cmp.lt), 64'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (cmp.done) cnt++;
    end
    chk("ign_no_second", 64'(cnt), 64'd0);

    // start held high: results every NUM_CHUNKS+2 cycles
    @(negedge clk);
    cmp.start = 1'b1; cmp.mode = 2'b10; cmp.A = 32'd7; cmp.B = 32'd7;
    wait_done(0, n);
    chk("b2b_first", 64'(n), 64'd6);
    chk("b2b_out1", 64'(cmp.OUT), 64'd1);
    wait_done(0, n);
    cmp.start = 1'b0;
    chk("b2b_spacing", 64'(n), 64'd6);
    chk("b2b_out2", 64'(cmp.OUT), 64'd1);
    chk("b2b_eq2", 64'(cmp.eq), 64'd1);

    // reset while RUN at idx=1
    @(negedge clk);
    cmp.start = 1'b1; cmp.mode = 2'b01; cmp.A = 32'd3; cmp.B = 32'd4;
    @(posedge clk); #1;
    cmp.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rmid_busy", 64'(cmp.busy), 64'd0);
    chk("rmid_out", 64'(cmp.OUT), 64'd0);
    chk("rmid_done", 64'(cmp.done), 64'd0);
    chk("rmid_eq", 64'(cmp.eq), 64'd0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (cmp.done) cnt++;
    end
    chk("rmid_no_done", 64'(cnt), 64'd0);
    run("fresh", 2'b01, 32'd3, 32'd4, 1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
